mul_share_arbiter: RTL and testbench

- Controller that time-shares one external array multiplier between two requesters.
- Round-robin arbitration, valid/ready handshakes on each request port and on a single tagged response port.
- Operand registers drive the multiplier, and a latency counter waits out its settle time before the product is captured.
- Sits between the tile I/O decode logic and the array multiplier instance inside the user project top.

---
 rtl/mul_share_if.sv | 49 ++++
 rtl/mul_share_arbiter.sv | 111 +++++++++++
 tb/tb_mul_share_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_if.sv
// mul_share_if: handshake bundle around mul_share_arbiter.
//   req0_*/req1_* : two requester ports (valid, operands a/b, ready)
//   mul_a/mul_b   : registered operands to the external multiplier
//   mul_p         : product returned by the external multiplier
//   rsp_*         : single tagged response port (valid, id, product, ready)
// Modports:
//   master : the arbiter side (drives ready, multiplier operands and response)
//   slave  : the surrounding logic (requesters, multiplier, response consumer)
interface mul_share_if #(
  parameter int WIDTH = 4
);
  logic               req0_valid;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req0_ready;
  logic               req1_valid;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               req1_ready;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_p;
  logic               rsp_valid;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_p;
  logic               rsp_ready;

  modport master (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output mul_a, mul_b,
    input  mul_p,
    output rsp_valid, rsp_id, rsp_p,
    input  rsp_ready
  );

  modport slave (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  mul_a, mul_b,
    output mul_p,
    input  rsp_valid, rsp_id, rsp_p,
    output rsp_ready
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: time-shares one external array multiplier between two
// requesters with round-robin arbitration and a single tagged response port.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mul_share_if.master (requests, multiplier operands/product, response)
// Parameters:
//   WIDTH   : operand width, product is 2*WIDTH (must match the interface)
//   MUL_LAT : cycles from operand register update to a settled mul_p (>= 1)
// Build option:
//   ZERO_BYPASS_EN : when defined, a granted request with a zero operand skips
//                    the multiplier wait and answers 0 on the next cycle.
module mul_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int MUL_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mul_share_if.master   bus
);
  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state;
  logic                 ptr;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     mul_a_q, mul_b_q;
  logic                 rsp_valid_q, rsp_id_q;
  logic [2*WIDTH-1:0]   rsp_p_q;

  logic [1:0]             vld;
  logic [1:0][WIDTH-1:0]  opa, opb;
  logic                   gnt;
  logic                   hs;
  logic [WIDTH-1:0]       gnt_a, gnt_b;
  logic                   zero_op;

  assign vld = {bus.req1_valid, bus.req0_valid};
  assign opa = {bus.req1_a, bus.req0_a};
  assign opb = {bus.req1_b, bus.req0_b};

  // Single requester wins outright; a tie goes to the round-robin pointer.
  assign gnt   = (&vld) ? ptr : vld[1];
  assign gnt_a = opa[gnt];
  assign gnt_b = opb[gnt];

  // Ready never depends on anything but valid and state, so no loop through
  // the requester. Held low while reset is asserted.
  assign hs             = !rst && (state == IDLE) && (|vld);
  assign bus.req0_ready = hs && !gnt;
  assign bus.req1_ready = hs && gnt;

`ifdef ZERO_BYPASS_EN
  assign zero_op = (gnt_a == '0) || (gnt_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      cnt         <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_p_q     <= '0;
    end else begin
      unique case (state)
        IDLE: if (hs) begin
          mul_a_q  <= gnt_a;
          mul_b_q  <= gnt_b;
          rsp_id_q <= gnt;
          ptr      <= ~gnt;
          if (zero_op) begin
            rsp_p_q     <= '0;
            rsp_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= RESP;
          end else begin
            cnt   <= CW'(MUL_LAT);
            state <= WAIT;
          end
        end
        // cnt counts MUL_LAT..1 over the wait edges; the edge that takes it
        // to zero is MUL_LAT edges after the operand update, so mul_p has
        // settled when sampled there.
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            rsp_p_q     <= bus.mul_p;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter. Two instances run side by side
// (MUL_LAT=1 and MUL_LAT=3) against a transaction-level reference model.
module tb_mul_share_arbiter;
  localparam int W    = 4;
  localparam int PW   = 2 * W;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_share_if #(.WIDTH(W)) if0 ();
  mul_share_if #(.WIDTH(W)) if1 ();

  mul_share_arbiter #(.WIDTH(W), .MUL_LAT(LAT0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mul_share_arbiter #(.WIDTH(W), .MUL_LAT(LAT1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // stimulus, indexed [dut][requester]
  bit           v  [2][2];
  logic [W-1:0] a  [2][2];
  logic [W-1:0] b  [2][2];
  bit           rr [2];

  assign if0.req0_valid = v[0][0];
  assign if0.req0_a     = a[0][0];
  assign if0.req0_b     = b[0][0];
  assign if0.req1_valid = v[0][1];
  assign if0.req1_a     = a[0][1];
  assign if0.req1_b     = b[0][1];
  assign if0.rsp_ready  = rr[0];
  assign if1.req0_valid = v[1][0];
  assign if1.req0_a     = a[1][0];
  assign if1.req0_b     = b[1][0];
  assign if1.req1_valid = v[1][1];
  assign if1.req1_a     = a[1][1];
  assign if1.req1_b     = b[1][1];
  assign if1.rsp_ready  = rr[1];

  logic           o_r  [2][2];
  logic           o_rv [2];
  logic           o_rid[2];
  logic [W-1:0]   o_ma [2];
  logic [W-1:0]   o_mb [2];
  logic [PW-1:0]  o_rp [2];

  assign o_r[0][0] = if0.req0_ready;
  assign o_r[0][1] = if0.req1_ready;
  assign o_r[1][0] = if1.req0_ready;
  assign o_r[1][1] = if1.req1_ready;
  assign o_rv[0]   = if0.rsp_valid;
  assign o_rv[1]   = if1.rsp_valid;
  assign o_rid[0]  = if0.rsp_id;
  assign o_rid[1]  = if1.rsp_id;
  assign o_rp[0]   = if0.rsp_p;
  assign o_rp[1]   = if1.rsp_p;
  assign o_ma[0]   = if0.mul_a;
  assign o_ma[1]   = if1.mul_a;
  assign o_mb[0]   = if0.mul_b;
  assign o_mb[1]   = if1.mul_b;

  // Multiplier model: output is X until the operands have been stable long
  // enough to be sampled MUL_LAT edges after they changed.
  logic [PW-1:0] op_now [2];
  logic [PW-1:0] op_last[2];
  int            age    [2] = '{8, 8};
  assign op_now[0] = {if0.mul_a, if0.mul_b};
  assign op_now[1] = {if1.mul_a, if1.mul_b};
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      op_last[k] <= op_now[k];
      if (op_now[k] !== op_last[k]) age[k] <= 1;
      else if (age[k] < 8)          age[k] <= age[k] + 1;
    end
  end
  assign if0.mul_p = (((op_now[0] !== op_last[0]) ? 0 : age[0]) >= LAT0 - 1) ?
                     PW'(if0.mul_a) * PW'(if0.mul_b) : 'x;
  assign if1.mul_p = (((op_now[1] !== op_last[1]) ? 0 : age[1]) >= LAT1 - 1) ?
                     PW'(if1.mul_a) * PW'(if1.mul_b) : 'x;

  // reference model: one outstanding transaction per instance
  bit           m_busy[2], m_rv[2], m_rid[2], m_ptr[2];
  logic [W-1:0] m_ma[2], m_mb[2];
  int           m_prod[2], m_rp[2], m_due[2];

  int n      = 0;
  int errs   = 0;
  int checks = 0;
  int mode   = 1;   // 0: hold requests, 1: drop after grant, 2: random
  bit rec    = 1'b0;
  int qid0[$], qid1[$], qp0[$], qp1[$];

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s dut%0d t=%0t got=%0h exp=%0h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic model_reset(int k);
    m_busy[k] = 0; m_rv[k] = 0; m_rid[k] = 0; m_ptr[k] = 0;
    m_ma[k] = '0; m_mb[k] = '0; m_rp[k] = 0; m_prod[k] = 0; m_due[k] = 0;
  endtask

  task automatic model_edge(int k, bit g0, bit g1);
    int g;
    bit zb;
    if (!m_busy[k]) begin
      if (g0 || g1) begin
        g         = g1 ? 1 : 0;
        m_busy[k] = 1;
        m_rid[k]  = (g == 1);
        m_ma[k]   = a[k][g];
        m_mb[k]   = b[k][g];
        m_ptr[k]  = (g == 0);
        m_prod[k] = int'(a[k][g]) * int'(b[k][g]);
        zb = 0;
`ifdef ZERO_BYPASS_EN
        zb = (a[k][g] == '0) || (b[k][g] == '0);
`endif
        if (zb) begin
          m_rv[k] = 1;
          m_rp[k] = 0;
        end else begin
          m_due[k] = n + ((k == 0) ? LAT0 : LAT1);
        end
      end
    end else if (!m_rv[k]) begin
      if (n == m_due[k]) begin
        m_rv[k] = 1;
        m_rp[k] = m_prod[k];
      end
    end else if (rr[k]) begin
      m_rv[k]   = 0;
      m_busy[k] = 0;
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    return ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 15));
  endfunction

  task automatic policy(int k, bit g0, bit g1);
    bit h[2];
    h[0] = g0;
    h[1] = g1;
    for (int r = 0; r < 2; r++) begin
      if (mode != 0 && h[r]) v[k][r] = 0;
      if (mode == 2 && !v[k][r] && $urandom_range(0, 2) == 0) begin
        v[k][r] = 1;
        a[k][r] = rnd_op();
        b[k][r] = rnd_op();
      end
    end
    if (mode == 2) rr[k] = ($urandom_range(0, 3) != 0);
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    bit er[2][2];
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      for (int r = 0; r < 2; r++)
        er[k][r] = !rst && !m_busy[k] && v[k][r] &&
                   (!v[k][1-r] || int'(m_ptr[k]) == r);
      chk("req0_ready", k, 32'(o_r[k][0]), 32'(er[k][0]));
      chk("req1_ready", k, 32'(o_r[k][1]), 32'(er[k][1]));
      chk("rsp_valid",  k, 32'(o_rv[k]),   32'(m_rv[k]));
      if (m_rv[k]) begin
        chk("rsp_id", k, 32'(o_rid[k]), 32'(m_rid[k]));
        chk("rsp_p",  k, 32'(o_rp[k]),  m_rp[k]);
      end
      chk("mul_a", k, 32'(o_ma[k]), 32'(m_ma[k]));
      chk("mul_b", k, 32'(o_mb[k]), 32'(m_mb[k]));
      if (rec && o_rv[k] === 1'b1 && rr[k]) begin
        if (k == 0) begin qid0.push_back(int'(o_rid[k])); qp0.push_back(int'(o_rp[k])); end
        else        begin qid1.push_back(int'(o_rid[k])); qp1.push_back(int'(o_rp[k])); end
      end
    end
    if (!rst) begin
      n++;
      for (int k = 0; k < 2; k++) model_edge(k, er[k][0], er[k][1]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) policy(k, er[k][0], er[k][1]);
    @(negedge clk);
  endtask

  task automatic set_req(int r, bit vv, int aa, int bb);
    for (int k = 0; k < 2; k++) begin
      v[k][r] = vv;
      a[k][r] = W'(aa);
      b[k][r] = W'(bb);
    end
  endtask

  task automatic check_contention(int k);
    int ids[$], ps[$];
    if (k == 0) begin ids = qid0; ps = qp0; end
    else        begin ids = qid1; ps = qp1; end
    chk("cont_count", k, 32'(ids.size() >= 4), 32'd1);
    for (int i = 0; i < ids.size(); i++) begin
      chk("cont_p", k, ps[i], (ids[i] == 1) ? 225 : 6);
      if (i > 0) chk("cont_alt", k, ids[i] ^ ids[i-1], 1);
    end
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      rr[k] = 1;
      for (int r = 0; r < 2; r++) begin
        v[k][r] = 0; a[k][r] = '0; b[k][r] = '0;
      end
    end
    @(negedge clk);

    // ready stays low while reset is held, even with a valid request
    set_req(0, 1, 7, 9);
    step(); step();
    rst = 1'b0;

    // single request 7*9
    repeat (6) step();

    // reset in the middle of an operation
    set_req(0, 1, 3, 5);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 0, 3, 5);
    step();
    set_req(0, 1, 3, 5);
    repeat (6) step();

    // contention: both continuously valid
    mode = 0;
    rec  = 1'b1;
    set_req(0, 1, 2, 3);
    set_req(1, 1, 15, 15);
    repeat (30) step();
    rec = 1'b0;
    set_req(0, 0, 2, 3);
    set_req(1, 0, 15, 15);
    repeat (6) step();
    check_contention(0);
    check_contention(1);
    mode = 1;

    // backpressure with a second request queued
    set_req(0, 1, 5, 6);
    set_req(1, 1, 9, 11);
    rr[0] = 0; rr[1] = 0;
    repeat (10) step();
    rr[0] = 1; rr[1] = 1;
    repeat (10) step();

    // full-scale product
    set_req(0, 1, 15, 15);
    repeat (8) step();

    // zero operand
    set_req(1, 1, 0, 12);
    repeat (8) step();

    // randomized traffic
    mode = 2;
    repeat (600) step();
    mode = 1;
    set_req(0, 0, 0, 0);
    set_req(1, 0, 0, 0);
    rr[0] = 1; rr[1] = 1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
